// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between KANAELE cache channels
// (0 = BC, 1 = DC, 2 = VC).
// One transaction at a time: IDLE picks a winner and captures its request.
// ZUGRIFF holds the RAM strobe until RAMFertig. RUECKGABE pulses the
// winner's KanalFertig bit and presents the result on DatenAusgabe.
// Optional macro RAM_ARBITER_ROUNDROBIN_EN: when defined, arbitration is
// round-robin; when undefined, it is fixed priority (lowest index wins).
// Ports:
//   Clock, Reset (async, active-low)
//   KanalSchreiben/KanalLesen  per-channel write/read requests
//   KanalAdresse/KanalDaten    packed per-channel address / write data
//   LeseDaten, RAMFertig       RAM read data and one-cycle completion
//   DatenAusgabe, KanalFertig  shared result bus, one-hot completion
//   Schreiben, Lesen, Adresse, SchreibDaten, WriteMask  RAM side
module ram_arbiter #(
   parameter int unsigned KANAELE        = 3,
   parameter int unsigned ADR_BREITE     = 23,
   parameter int unsigned RAM_ADR_BREITE = 26,
   parameter int unsigned DATEN_BREITE   = 32
) (
   input  logic                            Clock,
   input  logic                            Reset,
   input  logic [KANAELE-1:0]              KanalSchreiben,
   input  logic [KANAELE-1:0]              KanalLesen,
   input  logic [KANAELE*ADR_BREITE-1:0]   KanalAdresse,
   input  logic [KANAELE*DATEN_BREITE-1:0] KanalDaten,
   input  logic [DATEN_BREITE-1:0]         LeseDaten,
   input  logic                            RAMFertig,
   output logic [DATEN_BREITE-1:0]         DatenAusgabe,
   output logic [KANAELE-1:0]              KanalFertig,
   output logic                            Schreiben,
   output logic                            Lesen,
   output logic [RAM_ADR_BREITE-1:0]       Adresse,
   output logic [DATEN_BREITE-1:0]         SchreibDaten,
   output logic [DATEN_BREITE/8-1:0]       WriteMask
);

   localparam int unsigned IDX_W = (KANAELE > 1) ? $clog2(KANAELE) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'b001,
      S_ZUGRIFF   = 3'b010,
      S_RUECKGABE = 3'b100
   } state_t;

   state_t                      r_state, w_state_nxt;
   logic [IDX_W-1:0]            r_idx, w_idx_nxt;
   logic                        r_wr, w_wr_nxt;
   logic [ADR_BREITE-1:0]       r_adr, w_adr_nxt;
   logic [DATEN_BREITE-1:0]     r_daten, w_daten_nxt;
   logic                        r_schreiben, w_schreiben_nxt;
   logic                        r_lesen, w_lesen_nxt;
   logic [RAM_ADR_BREITE-1:0]   r_adresse, w_adresse_nxt;
   logic [DATEN_BREITE-1:0]     r_schreib_daten, w_schreib_daten_nxt;
   logic [KANAELE-1:0]          r_kanal_fertig, w_kanal_fertig_nxt;
   logic [DATEN_BREITE-1:0]     r_daten_aus, w_daten_aus_nxt;

   logic [KANAELE-1:0]          w_req;
   logic                        w_any;
   logic [IDX_W-1:0]            w_win;
   logic [ADR_BREITE-1:0]       w_sel_adr;
   logic [DATEN_BREITE-1:0]     w_sel_daten;

   // A channel asking for both operations is still just one request.
   assign w_req = KanalSchreiben | KanalLesen;
   assign w_any = |w_req;

`ifdef RAM_ARBITER_ROUNDROBIN_EN
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] w_cand;

   // Round-robin: walk distances KANAELE..1 from the last winner so the
   // closest requesting channel after it is the last one assigned.
   always_comb begin : win_sel
      w_win  = '0;
      w_cand = '0;
      for (int k = int'(KANAELE); k >= 1; k--) begin
         w_cand = IDX_W'((int'(r_rr_ptr) + k) % int'(KANAELE));
         if (w_req[w_cand]) w_win = w_cand;
      end
   end

   // Pointer moves only when a transaction is granted.
   always_ff @(posedge Clock or negedge Reset) begin : rr_ptr_reg
      if (!Reset) begin
         r_rr_ptr <= IDX_W'(KANAELE - 1);
      end else if ((r_state == S_IDLE) && w_any) begin
         r_rr_ptr <= w_win;
      end
   end
`else
   // Fixed priority: descending scan leaves the lowest requester.
   always_comb begin : win_sel
      w_win = '0;
      for (int k = int'(KANAELE) - 1; k >= 0; k--) begin
         if (w_req[k]) w_win = IDX_W'(k);
      end
   end
`endif

   // Select the winner's address and write data slices.
   always_comb begin : slice_sel
      w_sel_adr   = '0;
      w_sel_daten = '0;
      for (int k = 0; k < int'(KANAELE); k++) begin
         if (IDX_W'(k) == w_win) begin
            w_sel_adr   = KanalAdresse[k*ADR_BREITE +: ADR_BREITE];
            w_sel_daten = KanalDaten[k*DATEN_BREITE +: DATEN_BREITE];
         end
      end
   end

   // Next state plus next values of the registered outputs.
   always_comb begin : fsm_nxt
      w_state_nxt         = r_state;
      w_idx_nxt           = r_idx;
      w_wr_nxt            = r_wr;
      w_adr_nxt           = r_adr;
      w_daten_nxt         = r_daten;
      w_schreiben_nxt     = 1'b0;
      w_lesen_nxt         = 1'b0;
      w_adresse_nxt       = '0;
      w_schreib_daten_nxt = '0;
      w_kanal_fertig_nxt  = '0;
      w_daten_aus_nxt     = r_daten_aus;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt         = S_ZUGRIFF;
               w_idx_nxt           = w_win;
               w_wr_nxt            = KanalSchreiben[w_win];
               w_adr_nxt           = w_sel_adr;
               w_daten_nxt         = w_sel_daten;
               w_schreiben_nxt     = KanalSchreiben[w_win];
               w_lesen_nxt         = ~KanalSchreiben[w_win];
               w_adresse_nxt       = RAM_ADR_BREITE'(w_sel_adr);
               w_schreib_daten_nxt = w_sel_daten;
            end
         end
         S_ZUGRIFF: begin
            if (RAMFertig) begin
               w_state_nxt        = S_RUECKGABE;
               w_kanal_fertig_nxt = KANAELE'(1) << r_idx;
               w_daten_aus_nxt    = r_wr ? r_daten : LeseDaten;
            end else begin
               w_schreiben_nxt     = r_wr;
               w_lesen_nxt         = ~r_wr;
               w_adresse_nxt       = RAM_ADR_BREITE'(r_adr);
               w_schreib_daten_nxt = r_daten;
            end
         end
         S_RUECKGABE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, captured request and output registers.
   always_ff @(posedge Clock or negedge Reset) begin : state_reg
      if (!Reset) begin
         r_state         <= S_IDLE;
         r_idx           <= '0;
         r_wr            <= 1'b0;
         r_adr           <= '0;
         r_daten         <= '0;
         r_schreiben     <= 1'b0;
         r_lesen         <= 1'b0;
         r_adresse       <= '0;
         r_schreib_daten <= '0;
         r_kanal_fertig  <= '0;
         r_daten_aus     <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_idx           <= w_idx_nxt;
         r_wr            <= w_wr_nxt;
         r_adr           <= w_adr_nxt;
         r_daten         <= w_daten_nxt;
         r_schreiben     <= w_schreiben_nxt;
         r_lesen         <= w_lesen_nxt;
         r_adresse       <= w_adresse_nxt;
         r_schreib_daten <= w_schreib_daten_nxt;
         r_kanal_fertig  <= w_kanal_fertig_nxt;
         r_daten_aus     <= w_daten_aus_nxt;
      end
   end

   assign Schreiben    = r_schreiben;
   assign Lesen        = r_lesen;
   assign Adresse      = r_adresse;
   assign SchreibDaten = r_schreib_daten;
   assign KanalFertig  = r_kanal_fertig;
   assign DatenAusgabe = r_daten_aus;
   assign WriteMask    = '1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a transaction-level arbitration model
// predicts the grant sequence, a RAM responder records what the DUT asked for,
// and a monitor compares every KanalFertig against the queued prediction.
module tb_ram_arbiter;
   localparam int K   = 3;
   localparam int AW  = 23;
   localparam int RAW = 26;
   localparam int DW  = 32;

   logic              clk;
   logic              rst_n;
   logic [K-1:0]      ks;
   logic [K-1:0]      kl;
   logic [K*AW-1:0]   adr_all;
   logic [K*DW-1:0]   dat_all;
   logic [DW-1:0]     LeseDaten;
   logic              RAMFertig;
   logic [DW-1:0]     DatenAusgabe;
   logic [K-1:0]      KanalFertig;
   logic              Schreiben;
   logic              Lesen;
   logic [RAW-1:0]    Adresse;
   logic [DW-1:0]     SchreibDaten;
   logic [DW/8-1:0]   WriteMask;

   ram_arbiter #(.KANAELE(K), .ADR_BREITE(AW), .RAM_ADR_BREITE(RAW), .DATEN_BREITE(DW)) dut (
      .Clock(clk), .Reset(rst_n),
      .KanalSchreiben(ks), .KanalLesen(kl), .KanalAdresse(adr_all), .KanalDaten(dat_all),
      .LeseDaten(LeseDaten), .RAMFertig(RAMFertig),
      .DatenAusgabe(DatenAusgabe), .KanalFertig(KanalFertig),
      .Schreiben(Schreiben), .Lesen(Lesen), .Adresse(Adresse),
      .SchreibDaten(SchreibDaten), .WriteMask(WriteMask)
   );

   typedef struct {
      int            chan;
      bit            wr;
      logic [AW-1:0] adr;
      logic [DW-1:0] wd;
      logic [DW-1:0] res;
   } exp_t;

   typedef struct {
      logic [RAW-1:0] adr;
      logic           wr;
      logic           rd;
      logic [DW-1:0]  wd;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ram_delay = -1;
   int   spur_req = 0;
   int   spur_done = 0;
   int   model_ptr = K - 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [DW-1:0] ram_data(input logic [RAW-1:0] a);
      if (a == 26'h000ABCD) return 32'hDEADBEEF;
      return {a[15:0], 16'h0} ^ {6'h0, a} ^ 32'h5A5A_1234;
   endfunction

   // Reference arbitration: which pending channel is served next.
   function automatic int pick(input logic [K-1:0] m, input int last);
`ifdef RAM_ARBITER_ROUNDROBIN_EN
      for (int d = 1; d <= K; d++) if (m[(last + d) % K]) return (last + d) % K;
`else
      for (int c = 0; c < K; c++) if (m[c] && (last >= -1)) return c;
`endif
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic push_exp(input int c);
      exp_t e;
      e.chan = c;
      e.wr   = ks[c];
      e.adr  = adr_all[c*AW +: AW];
      e.wd   = dat_all[c*DW +: DW];
      e.res  = e.wr ? e.wd : ram_data(RAW'(e.adr));
      exp_q.push_back(e);
   endtask

   // Predict n grants; with drop=1 each served channel leaves the pending set.
   task automatic model_serve(input int n, input bit drop);
      logic [K-1:0] pend;
      int w;
      pend = ks | kl;
      for (int i = 0; i < n; i++) begin
         w = pick(pend, model_ptr);
         if (w < 0) break;
         model_ptr = w;
         push_exp(w);
         if (drop) pend[w] = 1'b0;
      end
   endtask

   // Wait for n completions; drop=1 releases each channel at its KanalFertig,
   // drop=0 holds all requests until the n-th completion.
   task automatic run_until(input int n, input bit drop);
      int done = 0;
      int cyc = 0;
      while (done < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < K; i++) begin
            if (KanalFertig[i]) begin
               done++;
               if (drop) begin
                  ks[i] = 1'b0;
                  kl[i] = 1'b0;
               end
            end
         end
      end
      if (!drop) begin
         ks = '0;
         kl = '0;
      end
      chk("completions", 64'(done), 64'(n));
   endtask

   // RAM model: records each access at its first strobe cycle, answers later.
   task automatic responder();
      bit busy = 0;
      bit fire_on = 0;
      int cnt = 0;
      obs_t o;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
            fire_on = 0;
            RAMFertig = 1'b0;
         end else if (fire_on) begin
            RAMFertig = 1'b0;
            LeseDaten = $urandom;
            fire_on = 0;
         end else if (spur_req != spur_done && !busy && !(Schreiben || Lesen)) begin
            spur_done = spur_req;
            RAMFertig = 1'b1;
            LeseDaten = 32'hBAD0_BAD0;
            fire_on = 1;
         end else begin
            if (!busy && (Schreiben || Lesen)) begin
               o.adr = Adresse;
               o.wr  = Schreiben;
               o.rd  = Lesen;
               o.wd  = SchreibDaten;
               obs_q.push_back(o);
               busy = 1;
               cnt = (ram_delay < 0) ? int'($urandom_range(0, 4)) : ram_delay;
            end
            if (busy) begin
               if (cnt == 0) begin
                  RAMFertig = 1'b1;
                  LeseDaten = ram_data(Adresse);
                  busy = 0;
                  fire_on = 1;
               end else begin
                  cnt--;
               end
            end
         end
      end
   endtask

   // Monitor: every completion is matched against the predicted transaction.
   task automatic monitor();
      exp_t e;
      obs_t o;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            obs_q.delete();
         end else if (KanalFertig != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_kanal_fertig", 64'(KanalFertig), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("kanal_fertig", 64'(KanalFertig), 64'(1) << e.chan);
               chk("daten_ausgabe", 64'(DatenAusgabe), 64'(e.res));
               chk("ram_access_seen", 64'(obs_q.size() > 0), 64'(1));
               if (obs_q.size() > 0) begin
                  o = obs_q.pop_front();
                  chk("ram_adresse", 64'(o.adr), 64'(RAW'(e.adr)));
                  chk("ram_schreiben", 64'(o.wr), 64'(e.wr));
                  chk("ram_lesen", 64'(o.rd), 64'(!e.wr));
                  chk("ram_schreibdaten", 64'(o.wd), 64'(e.wd));
               end
            end
         end
      end
   endtask

   initial begin
      int seen;
      logic [K-1:0] m;
      int op;
      rst_n = 1'b0;
      ks = '0;
      kl = '0;
      adr_all = '0;
      dat_all = '0;
      LeseDaten = '0;
      RAMFertig = 1'b0;
      fork
         responder();
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("reset_schreiben", 64'(Schreiben), 64'(0));
      chk("reset_lesen", 64'(Lesen), 64'(0));
      chk("reset_kanal_fertig", 64'(KanalFertig), 64'(0));
      chk("reset_daten_ausgabe", 64'(DatenAusgabe), 64'(0));
      chk("reset_adresse", 64'(Adresse), 64'(0));
      chk("reset_writemask", 64'(WriteMask), 64'(4'hF));
      rst_n = 1'b1;

      // Read on channel 1, RAM answers after 4 cycles.
      @(negedge clk);
      ram_delay = 4;
      kl = 3'b010;
      adr_all[1*AW +: AW] = 23'h00ABCD;
      model_serve(1, 1);
      @(negedge clk);
      chk("rd_strobe_latency", 64'(Lesen), 64'(1));
      chk("rd_no_schreiben", 64'(Schreiben), 64'(0));
      chk("rd_adresse", 64'(Adresse), 64'(26'h000ABCD));
      run_until(1, 1);

      // Write plus read on channel 2 is served as a write.
      @(negedge clk);
      ks = 3'b100;
      kl = 3'b100;
      dat_all[2*DW +: DW] = 32'h12345678;
      adr_all[2*AW +: AW] = 23'h012345;
      model_serve(1, 1);
      @(negedge clk);
      chk("wr_schreiben", 64'(Schreiben), 64'(1));
      chk("wr_no_lesen", 64'(Lesen), 64'(0));
      chk("wr_schreibdaten", 64'(SchreibDaten), 64'(32'h12345678));
      chk("wr_writemask", 64'(WriteMask), 64'(4'hF));
      run_until(1, 1);

      // Spurious RAMFertig while IDLE must not start or finish anything.
      ram_delay = -1;
      @(negedge clk);
      spur_req++;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (Schreiben || Lesen || (KanalFertig != '0)) seen++;
      end
      chk("spurious_no_activity", 64'(seen), 64'(0));

      // Channel 0 drops its write mid-access; it must still complete.
      @(negedge clk);
      ram_delay = 3;
      ks = 3'b001;
      dat_all[0 +: DW] = 32'hCAFE_F00D;
      adr_all[0 +: AW] = 23'h7FFFFF;
      model_serve(1, 1);
      @(negedge clk);
      @(negedge clk);
      chk("drop_strobe_held", 64'(Schreiben), 64'(1));
      ks = '0;
      run_until(1, 1);

      // All three channels request continuously for six transactions.
      @(negedge clk);
      ram_delay = -1;
      ks = 3'b010;
      kl = 3'b101;
      for (int i = 0; i < K; i++) begin
         adr_all[i*AW +: AW] = AW'($urandom);
         dat_all[i*DW +: DW] = $urandom;
      end
      model_serve(6, 0);
      run_until(6, 0);

      // Randomized rounds of simultaneous requests.
      for (int r = 0; r < 40; r++) begin
         @(negedge clk);
         m = K'($urandom_range(1, (1 << K) - 1));
         for (int i = 0; i < K; i++) begin
            op = int'($urandom_range(0, 2));
            ks[i] = m[i] && (op != 1);
            kl[i] = m[i] && (op != 0);
            adr_all[i*AW +: AW] = AW'($urandom);
            dat_all[i*DW +: DW] = $urandom;
         end
         model_serve($countones(m), 1);
         run_until($countones(m), 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset two cycles into an access: abandoned, outputs cleared at once.
      @(negedge clk);
      ram_delay = 10;
      kl = 3'b010;
      adr_all[1*AW +: AW] = 23'h055555;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_lesen", 64'(Lesen), 64'(0));
      chk("async_reset_adresse", 64'(Adresse), 64'(0));
      chk("async_reset_kanal_fertig", 64'(KanalFertig), 64'(0));
      chk("async_reset_daten_ausgabe", 64'(DatenAusgabe), 64'(0));
      ks = '0;
      kl = '0;
      model_ptr = K - 1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ram_delay = -1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (KanalFertig != '0) seen++;
      end
      chk("no_fertig_after_abort", 64'(seen), 64'(0));
      ks = 3'b100;
      dat_all[2*DW +: DW] = 32'hA5A5_5A5A;
      model_serve(1, 1);
      run_until(1, 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      chk("ram_log_drained", 64'(obs_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
